// File: rtl/uart_buf_pkg.sv
// Shared constants and state encoding for the UART receive-side text buffer blocks.
package uart_buf_pkg;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] SP = 8'h20;

  localparam int DEF_MAX_BYTES = 4;

  typedef enum logic [1:0] {
    HI      = 2'd0,
    LO      = 2'd1,
    DISCARD = 2'd2,
    HOLD    = 2'd3
  } state_t;
endpackage

// File: rtl/hex_nibble_dec.sv
// Combinational ASCII hex digit decoder: flags 0-9/A-F/a-f and returns the nibble value.
module hex_nibble_dec (
  input  logic [7:0] c,
  output logic       is_hex,
  output logic [3:0] nibble
);
  always_comb begin
    is_hex = 1'b1;
    nibble = 4'd0;
    if (c >= 8'h30 && c <= 8'h39) begin
      nibble = c[3:0];
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so adding 9 lands on 10
      nibble = c[3:0] + 4'd9;
    end else begin
      is_hex = 1'b0;
    end
  end
endmodule

// File: rtl/uart_rx_buf_con.sv
// Parses ASCII hex text lines from a UART receiver into a held 32-bit buffer with byte count.
// Optional echo path enabled by defining UART_RX_BUF_CON_ECHO_EN.
module uart_rx_buf_con
  import uart_buf_pkg::*;
#(
  parameter int MAX_BYTES = DEF_MAX_BYTES
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  rbus,
  input  logic        rvalid,
  output logic [31:0] rbuf,
  output logic [2:0]  bcount,
  output logic        line_valid,
  input  logic        ack,
  output logic        err,
  output logic        tstart,
  output logic [7:0]  tbus,
  input  logic        tready
);
  localparam logic [2:0] MAXC = 3'(MAX_BYTES);

  state_t     state;
  logic [3:0] nib;
  logic [2:0] cnt;
  logic       is_hex;
  logic [3:0] dig;

  hex_nibble_dec u_dec (
    .c      (rbus),
    .is_hex (is_hex),
    .nibble (dig)
  );

  assign line_valid = (state == HOLD);
  assign bcount     = (state == HOLD) ? cnt : 3'd0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= HI;
      nib   <= 4'd0;
      cnt   <= 3'd0;
      rbuf  <= 32'd0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        HI: begin
          if (rvalid) begin
            if (is_hex) begin
              nib   <= dig;
              state <= LO;
            end else if (rbus == CR) begin
              if (cnt != 3'd0) state <= HOLD;
            end else if (rbus != SP && rbus != LF) begin
              state <= DISCARD;
            end
          end
        end
        LO: begin
          if (rvalid && rbus != LF) begin
            if (is_hex) begin
              // overflow is judged before the increment so cnt never wraps
              if (cnt == MAXC) begin
                state <= DISCARD;
              end else begin
                rbuf  <= {rbuf[23:0], nib, dig};
                cnt   <= cnt + 3'd1;
                state <= HI;
              end
            end else if (rbus == CR) begin
              err   <= 1'b1;
              rbuf  <= 32'd0;
              cnt   <= 3'd0;
              state <= HI;
            end else begin
              state <= DISCARD;
            end
          end
        end
        DISCARD: begin
          if (rvalid && rbus == CR) begin
            err   <= 1'b1;
            rbuf  <= 32'd0;
            cnt   <= 3'd0;
            state <= HI;
          end
        end
        HOLD: begin
          // bytes arriving here are dropped; only ack matters
          if (ack) begin
            rbuf  <= 32'd0;
            cnt   <= 3'd0;
            state <= HI;
          end
        end
        default: state <= HI;
      endcase
    end
  end

`ifdef UART_RX_BUF_CON_ECHO_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tstart <= 1'b0;
      tbus   <= 8'd0;
    end else begin
      tstart <= 1'b0;
      if (rvalid && state != HOLD && tready) begin
        tstart <= 1'b1;
        tbus   <= rbus;
      end
    end
  end
`else
  logic unused_tready;
  assign unused_tready = tready;
  assign tstart = 1'b0;
  assign tbus   = 8'd0;
`endif
endmodule

// File: tb/tb_uart_rx_buf_con.sv
// Scoreboard bench for uart_rx_buf_con: driver queues expected events, monitor pops and compares.
module tb_uart_rx_buf_con;
  localparam int K_FALL = 0, K_LINE = 1, K_ERR = 2, K_ECHO = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  rbus;
  logic        rvalid;
  logic [31:0] rbuf;
  logic [2:0]  bcount;
  logic        line_valid;
  logic        ack;
  logic        err;
  logic        tstart;
  logic [7:0]  tbus;
  logic        tready;

  typedef struct {
    int          kind;
    int          ecyc;
    logic [31:0] rb;
    logic [2:0]  bc;
    logic [7:0]  tb;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  uart_rx_buf_con #(.MAX_BYTES(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rbus       (rbus),
    .rvalid     (rvalid),
    .rbuf       (rbuf),
    .bcount     (bcount),
    .line_valid (line_valid),
    .ack        (ack),
    .err        (err),
    .tstart     (tstart),
    .tbus       (tbus),
    .tready     (tready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int kind, input logic [31:0] rb, input logic [2:0] bc,
                      input logic [7:0] tb);
    exp_t e;
    e.kind = kind; e.ecyc = cyc + 1; e.rb = rb; e.bc = bc; e.tb = tb;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // send every char of s on consecutive cycles; expectation queued with the last char
  task automatic send_line(input string s, input int kind, input logic [31:0] rb,
                           input logic [2:0] bc);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      rbus   = s[i];
      rvalid = 1'b1;
      if (i == s.len() - 1 && kind >= 0) push(kind, rb, bc, 8'h00);
    end
    @(negedge clk);
    rvalid = 1'b0;
  endtask

  task automatic do_ack(input int wait_cycles);
    repeat (wait_cycles) @(negedge clk);
    ack = 1'b1;
    push(K_FALL, 32'd0, 3'd0, 8'd0);
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic on_event(input int kind, input string name);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: cyc=%0d rbuf=%h bcount=%0d tbus=%h, no event expected",
               name, cyc, rbuf, bcount, tbus);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.ecyc != cyc ||
          (kind == K_LINE && (rbuf !== e.rb || bcount !== e.bc)) ||
          (kind == K_ECHO && tbus !== e.tb)) begin
        errors++;
        $display("FAIL event_%s: got kind=%0d cyc=%0d rbuf=%h bcount=%0d tbus=%h; expected kind=%0d cyc=%0d rbuf=%h bcount=%0d tbus=%h",
                 name, kind, cyc, rbuf, bcount, tbus, e.kind, e.ecyc, e.rb, e.bc, e.tb);
      end
    end
  endtask

  initial begin : monitor
    logic        lv_prev;
    logic [31:0] hold_rb;
    logic [2:0]  hold_bc;
    lv_prev = 1'b0; hold_rb = '0; hold_bc = '0;
    forever begin
      @(negedge clk);
      if (line_valid && lv_prev) begin
        checks++;
        if (rbuf !== hold_rb || bcount !== hold_bc) begin
          errors++;
          $display("FAIL hold_stable: rbuf=%h bcount=%0d expected rbuf=%h bcount=%0d",
                   rbuf, bcount, hold_rb, hold_bc);
        end
      end
      if (!line_valid) begin
        checks++;
        if (bcount !== 3'd0) begin
          errors++;
          $display("FAIL bcount_idle: got %0d expected 0", bcount);
        end
      end
      if (!line_valid && lv_prev) on_event(K_FALL, "fall");
      if (line_valid && !lv_prev) begin
        on_event(K_LINE, "line");
        hold_rb = rbuf;
        hold_bc = bcount;
      end
      if (err === 1'b1) on_event(K_ERR, "err");
      if (tstart === 1'b1) on_event(K_ECHO, "echo");
      lv_prev = line_valid;
    end
  end

  initial begin
    rstn = 1'b1; rbus = 8'd0; rvalid = 1'b0; ack = 1'b0; tready = 1'b0;
    #1 rstn = 1'b0;
    #1;
    chk("rst_rbuf", rbuf, 32'd0);
    chk("rst_bcount", {29'd0, bcount}, 32'd0);
    chk("rst_line_valid", {31'd0, line_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_tstart", {31'd0, tstart}, 32'd0);
    chk("rst_tbus", {24'd0, tbus}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    send_line("1C F0 1C\015", K_LINE, 32'h001CF01C, 3'd3);
    do_ack(20);

    send_line("deadBEEF\015", K_LINE, 32'hDEADBEEF, 3'd4);
    do_ack(3);
    send_line("0102030405\015", K_ERR, 32'd0, 3'd0);

    send_line("1G\015", K_ERR, 32'd0, 3'd0);
    send_line("ABC\015", K_ERR, 32'd0, 3'd0);
    send_line("\015", -1, 32'd0, 3'd0);
    repeat (3) @(negedge clk);

    send_line("34\015", K_LINE, 32'h00000034, 3'd1);
    send_line("99\015", -1, 32'd0, 3'd0);
    // ack and a byte in the same cycle: the byte must be dropped
    @(negedge clk);
    ack = 1'b1; rbus = "5"; rvalid = 1'b1;
    push(K_FALL, 32'd0, 3'd0, 8'd0);
    @(negedge clk);
    ack = 1'b0; rvalid = 1'b0;
    send_line("12\012\015", K_LINE, 32'h00000012, 3'd1);
    do_ack(2);

    send_line("AB", -1, 32'd0, 3'd0);
    chk("partial_rbuf", rbuf, 32'h000000AB);
    #3 rstn = 1'b0;
    #1;
    chk("async_rst_rbuf", rbuf, 32'd0);
    chk("async_rst_bcount", {29'd0, bcount}, 32'd0);
    chk("async_rst_line_valid", {31'd0, line_valid}, 32'd0);
    chk("async_rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    send_line("CD\015", K_LINE, 32'h000000CD, 3'd1);
    do_ack(2);

    tready = 1'b1;
    @(negedge clk);
    rbus = "A"; rvalid = 1'b1;
`ifdef UART_RX_BUF_CON_ECHO_EN
    push(K_ECHO, 32'd0, 3'd0, 8'h41);
`endif
    @(negedge clk);
    rbus = "5";
`ifdef UART_RX_BUF_CON_ECHO_EN
    push(K_ECHO, 32'd0, 3'd0, 8'h35);
`endif
    @(negedge clk);
    tready = 1'b0; rbus = 8'h0D;
    push(K_LINE, 32'h000000A5, 3'd1, 8'd0);
    @(negedge clk);
    rvalid = 1'b0;
    do_ack(2);

    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors += q.size();
      $display("FAIL missing_events: got %0d outstanding expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_buf_con.md
Name: uart_rx_buf_con

Overview:
- Receive-side counterpart of the keyboard UART transmit buffer controller.
- Consumes bytes strobed out of the UART receiver and parses ASCII hex text lines, e.g. "1C F0 1C\r".
- Packs the parsed bytes into a 32-bit buffer with a byte count, then holds the result for the host logic under a valid/ack handshake.
- Bad lines are discarded and reported with an error pulse.

Parameters:
- MAX_BYTES, 4, maximum bytes per line (legal range 1..4). A line with more bytes is an error.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- rbus  in  8  received byte from the UART receiver
- rvalid  in  1  one-cycle strobe; rbus is valid in that cycle
- rbuf  out  32  parsed bytes; the most recently parsed byte is in [7:0]; unused upper bytes are 0
- bcount  out  3  number of valid bytes in rbuf (1..MAX_BYTES)
- line_valid  out  1  rbuf and bcount are valid; held until ack
- ack  in  1  host has consumed the line
- err  out  1  one-cycle pulse when a bad line is terminated
- tstart  out  1  echo transmit strobe (ECHO_EN only)
- tbus  out  8  echo byte (ECHO_EN only)
- tready  in  1  UART transmitter idle (ECHO_EN only)

Behaviour:
- Reset (async assert, sync release): state=HI; rbuf=0; bcount=0; line_valid=0; err=0; tstart=0; tbus=0; internal nibble register=0.
- Only cycles with rvalid=1 advance the parser. rvalid is never back-pressured, so any byte that arrives in HOLD is dropped.
- Character classes:
  - hex digit: 0-9, A-F, a-f
  - SP: 0x20
  - CR: 0x0D, the line terminator
  - LF: 0x0A, ignored in every state
  - anything else: invalid
- States:
  - HI (expect high nibble):
    - hex: latch the nibble -> LO
    - SP: stay in HI
    - CR with 0 bytes: empty line, ignored, stay in HI
    - CR with >=1 byte: -> HOLD
    - invalid: -> DISCARD
  - LO (expect low nibble):
    - hex: byte = {nibble, digit}. If the count is already MAX_BYTES -> DISCARD. Otherwise rbuf <= {rbuf[23:0], byte}, count+1, -> HI.
    - SP, CR or invalid: odd digit count, -> DISCARD. A CR here goes straight to the CR handling in DISCARD: pulse err, -> HI.
  - DISCARD: ignore all bytes until CR. On CR: err=1 for exactly one cycle, rbuf=0, count=0, -> HI.
  - HOLD: line_valid=1, bcount=count. On ack=1: next cycle line_valid=0, rbuf=0, count=0, -> HI.
- Timing and output rules:
  - line_valid rises in the cycle after the terminating CR strobe (1-cycle latency).
  - ack is ignored outside HOLD.
  - If ack and rvalid occur in the same cycle while in HOLD, the byte is dropped.
  - rbuf and bcount are stable for the whole time line_valid is high.
  - When not in HOLD, bcount is 0.
  - Back-to-back rvalid strobes on consecutive cycles must be handled, with no dropped bytes outside HOLD.
- Width rule: the count saturates logic at MAX_BYTES. The 3-bit counter never wraps because the overflow check runs before the increment.

Optional Feature:
- Macro: UART_RX_BUF_CON_ECHO_EN.
- When defined: every byte accepted with rvalid, except in HOLD, is echoed.
  - If tready=1 in the strobe cycle: tbus<=rbus and tstart=1 for one cycle.
  - If tready=0: the echo is silently skipped. There is no echo queue.
  - Parsing is unaffected by the echo path.
- When undefined: tstart and tbus are constant 0, tready is unused, and no echo logic is synthesised.

Decomposition:
- Package uart_buf_pkg:
  - ASCII constants: CR=8'h0D, LF=8'h0A, SP=8'h20.
  - State encoding: HI, LO, DISCARD, HOLD.
  - Default MAX_BYTES.
- One sub-module, hex_nibble_dec: combinational ASCII -> {is_hex, nibble[3:0]}, shared with later UART text blocks.

Test Plan:
- "1C F0 1C\r" -> line_valid=1 one cycle after CR, rbuf=32'h001CF01C, bcount=3. Holds for 20 cycles until ack; line_valid=0 the cycle after ack.
- "deadBEEF\r" -> rbuf=32'hDEADBEEF, bcount=4. Follow with "0102030405\r" -> err pulses for exactly one cycle on the CR, no line_valid.
- "1G\r", then "ABC\r", then "\r" -> two err pulses and no line_valid; the lone CR produces nothing.
- During HOLD send "99\r", then ack, then "12\n\r" -> the bytes sent in HOLD are lost; next line gives rbuf=32'h00000012, bcount=1, and the LF is ignored.
- Assert rstn=0 asynchronously after "AB" mid-line, then release -> all outputs 0 immediately; "CD\r" then yields rbuf=32'h000000CD.
- ECHO_EN with tready=1 then 0 while sending "A5\r" -> tstart pulses with tbus=8'h41, 8'h35 while tready=1; no pulse on strobes where tready=0.
